intr_ctrl: RTL and testbench

Interrupt controller sitting beside the ControlBlock in the 18-bit processor. It owns the global interrupt enable and qualifies the input-ready (flg_i) and output-ready (flg_o) flags from IR_AC against per-source enables. It arbitrates between the two sources round-robin and raises a request that the ControlBlock honours at an instruction boundary. It then supplies the 13-bit vector loaded into PC_MD and tracks the in-service period until return-from-interrupt.

---
 rtl/intr_ctrl.sv | 142 ++++++++++++++
 tb/tb_intr_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl -- interrupt controller for the 18-bit processor.
//
// Owns the global interrupt enable. It qualifies the input-ready and
// output-ready flags with their per-source enables, and arbitrates
// round-robin between the two sources. It raises irq to the ControlBlock,
// supplies the 13-bit vector for PC_MD, and tracks the handler until iret.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous reset, active low
//   flg_i       input register full (level)
//   flg_o       output register empty (level)
//   en_i        input-source enable (level)
//   en_o        output-source enable (level)
//   ion         pulse: set the global enable
//   iof         pulse: clear the global enable
//   ack         pulse: interrupt accepted at a fetch boundary
//   iret        pulse: return from interrupt
//   glob_ie     global interrupt enable
//   irq         interrupt request to the ControlBlock
//   vec[12:0]   vector address, valid while irq or vec_load is high
//   src[1:0]    cause: 01 input, 10 output, 00 none
//   vec_load    one-cycle pulse: PC_MD loads vec into PC
//   in_service  handler running
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding; ion/iof act on glob_ie
// PEND    | irq raised, waiting for ack; withdrawn on drop or iof
// ENTRY   | one cycle: vec_load pulse, round-robin pointer updated
// SERVICE | handler running until iret; no nesting

module intr_ctrl #(
  parameter logic [12:0] VEC_I = 13'h1FF0,
  parameter logic [12:0] VEC_O = 13'h1FF8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flg_i,
  input  logic        flg_o,
  input  logic        en_i,
  input  logic        en_o,
  input  logic        ion,
  input  logic        iof,
  input  logic        ack,
  input  logic        iret,
  output logic        glob_ie,
  output logic        irq,
  output logic [12:0] vec,
  output logic [1:0]  src,
  output logic        vec_load,
  output logic        in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    ENTRY   = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t state;
  // Round-robin pointer: 0 = input served last, 1 = output served last.
  logic   last;

  logic rq_i;
  logic rq_o;
  logic win_i;
  logic cur_rq;

  assign rq_i   = flg_i & en_i;
  assign rq_o   = flg_o & en_o;
  // Input wins when it is alone, or when both request and output was served last.
  assign win_i  = rq_i & (~rq_o | last);
  // Request of the source that is currently latched; it is used for the withdrawal check.
  assign cur_rq = src[0] ? rq_i : rq_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      glob_ie    <= 1'b0;
      irq        <= 1'b0;
      vec        <= 13'd0;
      src        <= 2'b00;
      vec_load   <= 1'b0;
      in_service <= 1'b0;
    end else begin
      vec_load <= 1'b0;
      case (state)
        IDLE: begin
          // iof takes precedence over both ion and a new request.
          if (iof) begin
            glob_ie <= 1'b0;
          end else if (glob_ie && (rq_i || rq_o)) begin
            state <= PEND;
            irq   <= 1'b1;
            src   <= win_i ? 2'b01 : 2'b10;
            vec   <= win_i ? VEC_I : VEC_O;
          end else if (ion) begin
            glob_ie <= 1'b1;
          end
        end
        PEND: begin
          if (ack) begin
            glob_ie  <= 1'b0;
            irq      <= 1'b0;
            vec_load <= 1'b1;
            state    <= ENTRY;
          end else if (iof) begin
            glob_ie <= 1'b0;
            irq     <= 1'b0;
            src     <= 2'b00;
            state   <= IDLE;
          end else if (!cur_rq) begin
            // The other source is not substituted; it will arbitrate again from IDLE.
            irq   <= 1'b0;
            src   <= 2'b00;
            state <= IDLE;
          end
        end
        ENTRY: begin
          last       <= src[1];
          in_service <= 1'b1;
          state      <= SERVICE;
        end
        SERVICE: begin
          if (iret) begin
            glob_ie    <= 1'b1;
            src        <= 2'b00;
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  logic        clk;
  logic        rst;
  logic        flg_i, flg_o, en_i, en_o, ion, iof, ack, iret;
  logic        glob_ie, irq, vec_load, in_service;
  logic [12:0] vec;
  logic [1:0]  src;

  int checks   = 0;
  int failures = 0;

  intr_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flg_i      (flg_i),
    .flg_o      (flg_o),
    .en_i       (en_i),
    .en_o       (en_o),
    .ion        (ion),
    .iof        (iof),
    .ack        (ack),
    .iret       (iret),
    .glob_ie    (glob_ie),
    .irq        (irq),
    .vec        (vec),
    .src        (src),
    .vec_load   (vec_load),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the phase of the interrupt life cycle, plus the cause being served.
  localparam int P_IDLE = 0, P_PEND = 1, P_ENTRY = 2, P_SERVICE = 3;
  int m_phase;
  int m_gie;
  int m_src;   // 0 none, 1 input, 2 output
  int m_last;  // source served last, 1 input, 2 output

  task automatic model_reset();
    m_phase = P_IDLE;
    m_gie   = 0;
    m_src   = 0;
    m_last  = 2;
  endtask

  task automatic model_step();
    int ri, ro;
    ri = int'(flg_i & en_i);
    ro = int'(flg_o & en_o);
    case (m_phase)
      P_IDLE: begin
        if (iof) m_gie = 0;
        else if (m_gie == 1 && (ri == 1 || ro == 1)) begin
          if (ri == 1 && ro == 1) m_src = (m_last == 1) ? 2 : 1;
          else m_src = (ri == 1) ? 1 : 2;
          m_phase = P_PEND;
        end else if (ion) m_gie = 1;
      end
      P_PEND: begin
        if (ack) begin
          m_gie   = 0;
          m_phase = P_ENTRY;
        end else if (iof) begin
          m_gie   = 0;
          m_src   = 0;
          m_phase = P_IDLE;
        end else if ((m_src == 1 ? ri : ro) == 0) begin
          m_src   = 0;
          m_phase = P_IDLE;
        end
      end
      P_ENTRY: begin
        m_last  = m_src;
        m_phase = P_SERVICE;
      end
      default: begin
        if (iret) begin
          m_gie   = 1;
          m_src   = 0;
          m_phase = P_IDLE;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    int exp_src_bits;
    exp_src_bits = (m_src == 1) ? 1 : (m_src == 2) ? 2 : 0;
    chk({tag, ".glob_ie"}, int'(glob_ie), m_gie);
    chk({tag, ".irq"}, int'(irq), int'(m_phase == P_PEND));
    chk({tag, ".vec_load"}, int'(vec_load), int'(m_phase == P_ENTRY));
    chk({tag, ".in_service"}, int'(in_service), int'(m_phase == P_SERVICE));
    chk({tag, ".src"}, int'(src), exp_src_bits);
    if (m_phase == P_PEND || m_phase == P_ENTRY)
      chk({tag, ".vec"}, int'(vec), (m_src == 1) ? 32'h1FF0 : 32'h1FF8);
  endtask

  task automatic drive(input logic [7:0] v);
    {flg_i, flg_o, en_i, en_o, ion, iof, ack, iret} = v;
  endtask

  // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic [7:0] v);
    drive(v);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  in;   // {flg_i, flg_o, en_i, en_o, ion, iof, ack, iret}
    logic        gie;
    logic        irq;
    logic [1:0]  src;
    logic        vl;
    logic        ins;
    logic [12:0] vec;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] in, input logic gie, input logic irq_e,
                              input logic [1:0] s, input logic vl, input logic ins,
                              input logic [12:0] v);
    vec_t r;
    r.in = in; r.gie = gie; r.irq = irq_e; r.src = s; r.vl = vl; r.ins = ins; r.vec = v;
    return r;
  endfunction

  vec_t tv[24];

  initial begin
    // Directed sequence from reset; expected values are the outputs after each edge.
    tv[0]  = mk(8'b1010_1000, 1, 0, 2'b00, 0, 0, 13'h0);      // ion
    tv[1]  = mk(8'b1010_0000, 1, 1, 2'b01, 0, 0, 13'h1FF0);   // input pending
    tv[2]  = mk(8'b1010_0000, 1, 1, 2'b01, 0, 0, 13'h1FF0);   // held
    tv[3]  = mk(8'b1010_0010, 0, 0, 2'b01, 1, 0, 13'h1FF0);   // ack -> entry
    tv[4]  = mk(8'b1010_0000, 0, 0, 2'b01, 0, 1, 13'h0);      // service
    tv[5]  = mk(8'b1010_0010, 0, 0, 2'b01, 0, 1, 13'h0);      // ack ignored
    tv[6]  = mk(8'b1010_1100, 0, 0, 2'b01, 0, 1, 13'h0);      // ion/iof ignored
    tv[7]  = mk(8'b1010_0001, 1, 0, 2'b00, 0, 0, 13'h0);      // iret
    tv[8]  = mk(8'b1111_0000, 1, 1, 2'b10, 0, 0, 13'h1FF8);   // both: output wins
    tv[9]  = mk(8'b1011_0000, 1, 0, 2'b00, 0, 0, 13'h0);      // output withdrawn
    tv[10] = mk(8'b1011_0000, 1, 1, 2'b01, 0, 0, 13'h1FF0);   // input now
    tv[11] = mk(8'b1011_0100, 0, 0, 2'b00, 0, 0, 13'h0);      // iof in pend
    tv[12] = mk(8'b1011_1100, 0, 0, 2'b00, 0, 0, 13'h0);      // ion+iof
    tv[13] = mk(8'b1011_0001, 0, 0, 2'b00, 0, 0, 13'h0);      // iret in idle
    tv[14] = mk(8'b1111_1000, 1, 0, 2'b00, 0, 0, 13'h0);      // ion
    tv[15] = mk(8'b1111_0000, 1, 1, 2'b10, 0, 0, 13'h1FF8);   // output (input served last)
    tv[16] = mk(8'b1111_0110, 0, 0, 2'b10, 1, 0, 13'h1FF8);   // ack+iof
    tv[17] = mk(8'b1111_0000, 0, 0, 2'b10, 0, 1, 13'h0);
    tv[18] = mk(8'b1111_0001, 1, 0, 2'b00, 0, 0, 13'h0);      // iret
    tv[19] = mk(8'b1111_0000, 1, 1, 2'b01, 0, 0, 13'h1FF0);   // input again
    tv[20] = mk(8'b1111_0010, 0, 0, 2'b01, 1, 0, 13'h1FF0);
    tv[21] = mk(8'b0000_0000, 0, 0, 2'b01, 0, 1, 13'h0);
    tv[22] = mk(8'b0000_0001, 1, 0, 2'b00, 0, 0, 13'h0);
    tv[23] = mk(8'b0000_0000, 1, 0, 2'b00, 0, 0, 13'h0);

    // Reset held with a live qualified request.
    rst = 1'b0;
    drive(8'b1010_1000);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.glob_ie", int'(glob_ie), 0);
    chk("rst.irq", int'(irq), 0);
    chk("rst.vec", int'(vec), 0);
    chk("rst.src", int'(src), 0);
    chk("rst.vec_load", int'(vec_load), 0);
    chk("rst.in_service", int'(in_service), 0);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      cycle(tv[i].in);
      chk($sformatf("tv%0d.glob_ie", i), int'(glob_ie), int'(tv[i].gie));
      chk($sformatf("tv%0d.irq", i), int'(irq), int'(tv[i].irq));
      chk($sformatf("tv%0d.src", i), int'(src), int'(tv[i].src));
      chk($sformatf("tv%0d.vec_load", i), int'(vec_load), int'(tv[i].vl));
      chk($sformatf("tv%0d.in_service", i), int'(in_service), int'(tv[i].ins));
      if (tv[i].irq || tv[i].vl)
        chk($sformatf("tv%0d.vec", i), int'(vec), int'(tv[i].vec));
    end

    // Asynchronous reset in SERVICE, then the pointer must favour input again.
    cycle(8'b1111_0000);
    cycle(8'b1111_0010);
    cycle(8'b0000_0000);
    chk_model("pre_rst");
    chk("pre_rst.in_service_set", int'(in_service), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst.in_service", int'(in_service), 0);
    chk("async_rst.glob_ie", int'(glob_ie), 0);
    chk("async_rst.src", int'(src), 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    cycle(8'b1111_1000);
    cycle(8'b1111_0000);
    chk("post_rst.irq", int'(irq), 1);
    chk("post_rst.src", int'(src), 1);
    chk("post_rst.vec", int'(vec), 32'h1FF0);
    chk_model("post_rst");

    // Randomized traffic against the model.
    begin
      logic [7:0] v;
      logic fi, fo, ei, eo;
      fi = 1'b0; fo = 1'b0; ei = 1'b1; eo = 1'b1;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(3) == 0) fi = ~fi;
        if ($urandom_range(3) == 0) fo = ~fo;
        if ($urandom_range(15) == 0) ei = ~ei;
        if ($urandom_range(15) == 0) eo = ~eo;
        v = {fi, fo, ei, eo,
             logic'($urandom_range(5) == 0),
             logic'($urandom_range(11) == 0),
             logic'($urandom_range(3) == 0),
             logic'($urandom_range(4) == 0)};
        cycle(v);
        chk_model($sformatf("rnd%0d", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
